mul_issue_ctrl: RTL and testbench

- Handshake front/back end for the iterative array multiplier.
- Accepts operand pairs on a valid/ready interface and drives the multiplier's operand bus and start pulse.
- Waits a fixed number of clocks for the product to settle, captures it, and presents it on a valid/ready result interface.
- Sits directly upstream of the multiplier (feeds a, b, start) and also consumes its y output.

---
 rtl/mul_issue_if.sv | 31 +++
 rtl/mul_issue_ctrl.sv | 112 +++++++++++
 tb/tb_mul_issue_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mul_issue_if.sv
// Handshake bundle between the multiplier issue controller and its environment.
// Carries the operand valid/ready channel, the multiplier operand/start/product bus,
// the result valid/ready channel and the busy flag.
//   slave  : the issue controller (consumes operands and mul_y, drives the rest)
//   master : the environment (producer, consumer and multiplier)
interface mul_issue_if #(
  parameter int unsigned N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           mul_start;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic [2*N-1:0] mul_y;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_y;
  logic           busy;

  modport slave (
    input  in_valid, in_a, in_b, mul_y, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_y, busy
  );

  modport master (
    output in_valid, in_a, in_b, mul_y, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_y, busy
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the iterative array multiplier.
// Accepts an operand pair on a valid/ready channel, drives the multiplier's operand
// bus and a one-cycle start pulse, waits MUL_LAT clocks for the product to settle,
// captures it and offers it on a valid/ready result channel.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mul_issue_if.slave -- in_valid/in_ready/in_a/in_b, mul_start/mul_a/mul_b,
//           mul_y, out_valid/out_ready/out_y, busy
// Optional macro MUL_ISSUE_SIGNED_EN: operands are two's complement; the multiplier
// is fed magnitudes and the product sign is reapplied at capture.
module mul_issue_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned MUL_LAT = N + 1
) (
  input logic        clk,
  input logic        rst_n,
  mul_issue_if.slave bus
);

  localparam int unsigned CntW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            mul_start_q;
  logic [N-1:0]    mul_a_q;
  logic [N-1:0]    mul_b_q;
  logic            out_valid_q;
  logic [2*N-1:0]  out_y_q;
  logic [N-1:0]    a_mag;
  logic [N-1:0]    b_mag;
  logic [2*N-1:0]  y_cap;

`ifdef MUL_ISSUE_SIGNED_EN
  logic sign_q;

  // Negating -2^(N-1) wraps to itself, which read unsigned is the correct magnitude.
  always_comb begin
    a_mag = bus.in_a[N-1] ? (~bus.in_a + 1'b1) : bus.in_a;
    b_mag = bus.in_b[N-1] ? (~bus.in_b + 1'b1) : bus.in_b;
    y_cap = sign_q ? (~bus.mul_y + 1'b1) : bus.mul_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else if (state_q == StIdle && bus.in_valid) begin
      sign_q <= bus.in_a[N-1] ^ bus.in_b[N-1];
    end
  end
`else
  always_comb begin
    a_mag = bus.in_a;
    b_mag = bus.in_b;
    y_cap = bus.mul_y;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            mul_a_q     <= a_mag;
            mul_b_q     <= b_mag;
            mul_start_q <= 1'b1;
            state_q     <= StStart;
          end
        end
        StStart: begin
          mul_start_q <= 1'b0;
          cnt_q       <= CntW'(MUL_LAT);
          state_q     <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            out_y_q     <= y_cap;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

  localparam int unsigned N      = 4;
  localparam int unsigned MulLat = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   mul_cnt;
  int   prev_accept;

  mul_issue_if #(.N(N)) bus ();

  mul_issue_ctrl #(.N(N), .MUL_LAT(MulLat)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: the product only appears once MUL_LAT clocks have passed since
  // start dropped, so an early capture sees the 8'hA5 filler instead.
  always @(posedge clk) begin
    if (bus.mul_start) mul_cnt <= 0;
    else if (mul_cnt < 100) mul_cnt <= mul_cnt + 1;
  end
  assign bus.mul_y = (!bus.mul_start && mul_cnt >= int'(MulLat) - 1)
                     ? ({4'd0, bus.mul_a} * {4'd0, bus.mul_b}) : 8'hA5;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         hold;
    logic [7:0] exp_y;
    logic [3:0] exp_ma;
    logic [3:0] exp_mb;
    bit         b2b;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int k;
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_a      = v.a;
    bus.in_b      = v.b;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (v.b2b) check("accept_spacing", 32'(cyc - prev_accept), 32'(MulLat + 3));
    prev_accept = cyc;
    check("start_pulse_high", 32'(bus.mul_start), 32'd1);
    check("in_ready_low_busy", 32'({bus.in_ready, bus.busy}), 32'b01);
    check("mul_operands", 32'({bus.mul_a, bus.mul_b}), 32'({v.exp_ma, v.exp_mb}));
    k = 0;
    do begin
      @(posedge clk); #1; k++;
      if (k == 1) check("start_pulse_one_cycle", 32'(bus.mul_start), 32'd0);
    end while (!bus.out_valid && k < 30);
    check("latency", 32'(k), 32'(MulLat + 1));
    check("out_y", 32'(bus.out_y), 32'(v.exp_y));
    for (int i = 0; i < v.hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = ~v.a;
      bus.in_b     = ~v.b;
      @(posedge clk); #1;
      check("hold_valid_y_ready", 32'({bus.out_valid, bus.out_y, bus.in_ready}),
            32'({1'b1, v.exp_y, 1'b0}));
      check("hold_operands", 32'({bus.mul_a, bus.mul_b}), 32'({v.exp_ma, v.exp_mb}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_to_idle", 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'b010);
  endtask

  initial begin
    int seen;
    checks = 0; errors = 0; cyc = 0; mul_cnt = 100; prev_accept = 0;
`ifdef MUL_ISSUE_SIGNED_EN
    vecs.push_back('{4'h8, 4'h0, 0, 8'h00, 4'h8, 4'h0, 1'b0});
    vecs.push_back('{4'h8, 4'h8, 0, 8'h40, 4'h8, 4'h8, 1'b1});
    vecs.push_back('{4'hD, 4'h5, 3, 8'hF1, 4'h3, 4'h5, 1'b1});
`else
    vecs.push_back('{4'd13, 4'd11, 0, 8'h8F, 4'd13, 4'd11, 1'b0});
    vecs.push_back('{4'd15, 4'd15, 10, 8'hE1, 4'd15, 4'd15, 1'b0});
    vecs.push_back('{4'd0, 4'd9, 0, 8'h00, 4'd0, 4'd9, 1'b0});
    vecs.push_back('{4'd1, 4'd15, 0, 8'h0F, 4'd1, 4'd15, 1'b1});
`endif
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check("reset_outputs", 32'({bus.in_ready, bus.busy, bus.mul_start, bus.out_valid}),
          32'b1000);
    check("reset_bus", 32'({bus.mul_a, bus.mul_b, bus.out_y}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // out_ready while nothing is pending must not change anything
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle_out_ready", 32'({bus.out_valid, bus.in_ready}), 32'b01);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset in the middle of WAIT: outputs return before any clock edge.
    bus.in_valid = 1'b1; bus.in_a = 4'd7; bus.in_b = 4'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_wait_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", 32'({bus.in_ready, bus.busy, bus.mul_start, bus.out_valid}),
          32'b1000);
    check("async_reset_bus", 32'({bus.mul_a, bus.mul_b, bus.out_y}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("no_valid_after_reset", 32'(seen), 32'd0);
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);

    run_op(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
